// File: rtl/hm_read_sched_if.sv
// Request/completion/control bundle between the page-read scheduler and its
// control FSM, TX engine and RX engine.
interface hm_read_sched_if #(
  parameter int unsigned TAG_W   = 2,
  parameter int unsigned CHUNK_W = 2
);
  logic               start;
  logic               abort;
  logic [63:0]        page_addr;
  logic               busy;
  logic               done;
  logic               error;
  logic               req_valid;
  logic               req_ready;
  logic [63:0]        req_addr;
  logic [TAG_W-1:0]   req_tag;
  logic [10:0]        req_len_dw;
  logic               cpl_valid;
  logic [TAG_W-1:0]   cpl_tag;
  logic [CHUNK_W-1:0] cpl_chunk;
  logic [15:0]        stat_cpt_req;
  logic [7:0]         stat_cpt_stray;

  modport master (
    input  start, abort, page_addr, req_ready, cpl_valid, cpl_tag,
    output busy, done, error, req_valid, req_addr, req_tag, req_len_dw,
           cpl_chunk, stat_cpt_req, stat_cpt_stray
  );

  modport slave (
    output start, abort, page_addr, req_ready, cpl_valid, cpl_tag,
    input  busy, done, error, req_valid, req_addr, req_tag, req_len_dw,
           cpl_chunk, stat_cpt_req, stat_cpt_stray
  );
endinterface

// File: rtl/hm_read_sched.sv
// Tagged multi-outstanding page-read scheduler: splits a page into chunk reads.
// Optional statistics counters are built when HM_SCHED_STATS_EN is defined.
module hm_read_sched #(
  parameter int unsigned PAGE_BYTES     = 4096,
  parameter int unsigned CHUNK_BYTES    = 1024,
  parameter int unsigned TAG_W          = 2,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input logic             trn_clk,
  input logic             trn_reset_n,
  hm_read_sched_if.master bus
);

  localparam int unsigned N_CHUNK  = PAGE_BYTES / CHUNK_BYTES;
  localparam int unsigned CHUNK_W  = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1;
  localparam int unsigned IDX_W    = CHUNK_W + 1;
  localparam int unsigned MAX_OUT  = 1 << TAG_W;
  localparam int unsigned CHUNK_SH = $clog2(CHUNK_BYTES);
  localparam int unsigned TMO_W    = 16;
  localparam logic [63:0] PAGE_MSK = ~(64'(PAGE_BYTES) - 64'd1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t             state_q, state_d;
  logic [63:0]        base_q, base_d;
  logic [IDX_W-1:0]   idx_q, idx_d, idx_upd;
  logic [MAX_OUT-1:0] mask_q, mask_d, mask_upd, hs_oh, cpl_oh;
  logic [CHUNK_W-1:0] tag_chunk_q [MAX_OUT];
  logic [TMO_W-1:0]   timer_q, timer_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic               req_valid_q, req_valid_d;
  logic [63:0]        req_addr_q, req_addr_d;
  logic [TAG_W-1:0]   req_tag_q, req_tag_d;
  logic               hs, cpl_ok, timeout;

  function automatic logic [TAG_W-1:0] lowest_free(input logic [MAX_OUT-1:0] m);
    lowest_free = '0;
    for (int i = MAX_OUT - 1; i >= 0; i--) begin
      if (!m[i]) lowest_free = TAG_W'(i);
    end
  endfunction

  // Per-cycle events; req_valid_q is only ever high in RUN
  assign hs      = (state_q == S_RUN) && req_valid_q && bus.req_ready;
  assign cpl_ok  = (state_q == S_RUN) && bus.cpl_valid && mask_q[bus.cpl_tag];
  assign timeout = (state_q == S_RUN) && (timer_q == TMO_W'(TIMEOUT_CYCLES));

  assign hs_oh    = hs ? (MAX_OUT'(1) << req_tag_q) : '0;
  assign cpl_oh   = cpl_ok ? (MAX_OUT'(1) << bus.cpl_tag) : '0;
  assign mask_upd = (mask_q | hs_oh) & ~cpl_oh;
  assign idx_upd  = idx_q + IDX_W'(hs);

  // State register
  always_ff @(posedge trn_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) state_q <= S_IDLE;
    else              state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.start) state_d = S_RUN;
      S_RUN: begin
        if (bus.abort || timeout) state_d = S_IDLE;
        else if (idx_upd == IDX_W'(N_CHUNK) && mask_upd == '0) state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values; registered outputs look one state ahead
  always_comb begin
    base_d  = base_q;
    idx_d   = idx_upd;
    mask_d  = mask_upd;
    timer_d = (hs || cpl_ok) ? '0 : timer_q + TMO_W'(1);
    if (state_q == S_IDLE) begin
      timer_d = '0;
      if (bus.start) begin
        base_d = bus.page_addr & PAGE_MSK;
        idx_d  = '0;
        mask_d = '0;
      end
    end
    if (state_d == S_IDLE) begin
      mask_d  = '0;
      timer_d = '0;
    end
    busy_d      = (state_d != S_IDLE) || (state_q == S_FIN && !bus.abort);
    done_d      = (state_q == S_FIN) && !bus.abort;
    error_d     = timeout && !bus.abort;
    req_valid_d = (state_d == S_RUN) && (idx_d < IDX_W'(N_CHUNK)) && (mask_d != '1);
    // Hold the presented tag until it is accepted
    req_tag_d   = (req_valid_q && !bus.req_ready && state_d == S_RUN) ? req_tag_q
                                                                      : lowest_free(mask_d);
    req_addr_d  = base_d + (64'(idx_d) << CHUNK_SH);
  end

  always_ff @(posedge trn_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      base_q      <= '0;
      idx_q       <= '0;
      mask_q      <= '0;
      timer_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_tag_q   <= '0;
      for (int i = 0; i < MAX_OUT; i++) tag_chunk_q[i] <= '0;
    end else begin
      base_q      <= base_d;
      idx_q       <= idx_d;
      mask_q      <= mask_d;
      timer_q     <= timer_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      req_tag_q   <= req_tag_d;
      if (hs) tag_chunk_q[req_tag_q] <= idx_q[CHUNK_W-1:0];
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;
  assign bus.req_valid  = req_valid_q;
  assign bus.req_addr   = req_addr_q;
  assign bus.req_tag    = req_tag_q;
  assign bus.req_len_dw = 11'(CHUNK_BYTES / 4);
  assign bus.cpl_chunk  = tag_chunk_q[bus.cpl_tag];

`ifdef HM_SCHED_STATS_EN
  logic        stray;
  logic [15:0] stat_req_q;
  logic [7:0]  stat_stray_q;

  assign stray = bus.cpl_valid && !cpl_ok;

  // Request count wraps, stray count saturates
  always_ff @(posedge trn_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      stat_req_q   <= '0;
      stat_stray_q <= '0;
    end else begin
      if (hs) stat_req_q <= stat_req_q + 16'd1;
      if (stray && stat_stray_q != 8'hFF) stat_stray_q <= stat_stray_q + 8'd1;
    end
  end

  assign bus.stat_cpt_req   = stat_req_q;
  assign bus.stat_cpt_stray = stat_stray_q;
`else
  assign bus.stat_cpt_req   = '0;
  assign bus.stat_cpt_stray = '0;
`endif

endmodule

// File: tb/tb_hm_read_sched.sv
// Scoreboard bench for hm_read_sched: a 4-chunk instance and an 8-chunk instance
// share clock and reset; expected requests are queued at start and popped on handshake.
`timescale 1ns/1ps
module tb_hm_read_sched;

`ifdef HM_SCHED_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hm_read_sched_if #(.TAG_W(2), .CHUNK_W(2)) a_if ();
  hm_read_sched_if #(.TAG_W(2), .CHUNK_W(3)) b_if ();

  hm_read_sched #(.PAGE_BYTES(4096), .CHUNK_BYTES(1024), .TAG_W(2), .TIMEOUT_CYCLES(100))
    u_a (.trn_clk(clk), .trn_reset_n(rst_n), .bus(a_if.master));
  hm_read_sched #(.PAGE_BYTES(4096), .CHUNK_BYTES(512), .TAG_W(2), .TIMEOUT_CYCLES(100))
    u_b (.trn_clk(clk), .trn_reset_n(rst_n), .bus(b_if.master));

  typedef struct { logic [63:0] addr; logic [1:0] tag; int idx; } req_t;
  typedef struct { int due; logic [1:0] tag; int idx; } cpl_t;

  req_t exp_q[$];
  cpl_t cpl_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic test_reset();
    n_checks++;
    if ({a_if.busy, a_if.done, a_if.error, a_if.req_valid} !== 4'b0)
      $display("FAIL reset_flags got %b exp 0000", {a_if.busy, a_if.done, a_if.error, a_if.req_valid});
    else n_pass++;
    n_checks++;
    if (a_if.req_addr !== 64'h0 || a_if.req_tag !== 2'd0)
      $display("FAIL reset_req got %h/%0d exp 0/0", a_if.req_addr, a_if.req_tag);
    else n_pass++;
    n_checks++;
    if (a_if.stat_cpt_req !== 16'd0 || a_if.stat_cpt_stray !== 8'd0)
      $display("FAIL reset_stats got %0d/%0d exp 0/0", a_if.stat_cpt_req, a_if.stat_cpt_stray);
    else n_pass++;
    n_checks++;
    if (b_if.busy !== 1'b0 || b_if.req_valid !== 1'b0)
      $display("FAIL reset_b got %b%b exp 00", b_if.busy, b_if.req_valid);
    else n_pass++;
  endtask

  task automatic test_page_read(input string nm);
    int last_hs, last_cpl, done_k, done_cnt;
    req_t e;
    cpl_t c;
    exp_q.delete();
    cpl_q.delete();
    for (int i = 0; i < 4; i++) begin
      e.addr = 64'h1_2345_6000 + 64'(i) * 64'h400;
      e.tag  = 2'(i);
      e.idx  = i;
      exp_q.push_back(e);
    end
    @(negedge clk);
    a_if.page_addr = 64'h1_2345_6ABC;
    a_if.req_ready = 1'b1;
    a_if.start     = 1'b1;
    @(negedge clk);
    a_if.start = 1'b0;
    n_checks++;
    if (a_if.busy !== 1'b1 || a_if.req_valid !== 1'b1)
      $display("FAIL %s start_latency got busy=%b valid=%b exp 1 1", nm, a_if.busy, a_if.req_valid);
    else n_pass++;
    n_checks++;
    if (a_if.req_len_dw !== 11'd256) $display("FAIL %s len_dw got %0d exp 256", nm, a_if.req_len_dw);
    else n_pass++;
    last_hs = -1; last_cpl = -1; done_k = -1; done_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      a_if.cpl_valid = 1'b0;
      if (cpl_q.size() > 0 && cpl_q[0].due == k) begin
        c = cpl_q.pop_front();
        a_if.cpl_valid = 1'b1;
        a_if.cpl_tag   = c.tag;
        #1;
        n_checks++;
        if (a_if.cpl_chunk !== 2'(c.idx))
          $display("FAIL %s cpl_chunk got %0d exp %0d", nm, a_if.cpl_chunk, c.idx);
        else n_pass++;
        last_cpl = k;
      end
      if (a_if.req_valid && a_if.req_ready) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL %s extra_req got tag %0d exp none", nm, a_if.req_tag);
        else begin
          e = exp_q.pop_front();
          if (a_if.req_addr !== e.addr || a_if.req_tag !== e.tag)
            $display("FAIL %s req got %h/%0d exp %h/%0d", nm, a_if.req_addr, a_if.req_tag, e.addr, e.tag);
          else n_pass++;
          if (last_hs >= 0) begin
            n_checks++;
            if (k != last_hs + 1) $display("FAIL %s back_to_back got cycle %0d exp %0d", nm, k, last_hs + 1);
            else n_pass++;
          end
          last_hs = k;
          c.due = k + 3; c.tag = e.tag; c.idx = e.idx;
          cpl_q.push_back(c);
        end
      end
      if (a_if.done) begin done_cnt++; done_k = k; end
      if (done_k >= 0 && k == done_k + 1) begin
        n_checks++;
        if (a_if.busy !== 1'b0) $display("FAIL %s busy_after_done got %b exp 0", nm, a_if.busy);
        else n_pass++;
      end
      @(negedge clk);
    end
    a_if.cpl_valid = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL %s missing_req got %0d left exp 0", nm, exp_q.size());
    else n_pass++;
    n_checks++;
    if (done_cnt != 1 || done_k != last_cpl + 2)
      $display("FAIL %s done got count %0d at %0d exp 1 at %0d", nm, done_cnt, done_k, last_cpl + 2);
    else n_pass++;
    n_checks++;
    if (a_if.stat_cpt_req !== 16'(STATS * 4))
      $display("FAIL %s stat_req got %0d exp %0d", nm, a_if.stat_cpt_req, STATS * 4);
    else n_pass++;
  endtask

  task automatic test_hold_back();
    int hs_cnt;
    req_t e;
    logic [63:0] base = 64'hABCD_E000;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      e.addr = base + 64'(i) * 64'h200; e.tag = 2'(i); e.idx = i;
      exp_q.push_back(e);
    end
    @(negedge clk);
    b_if.page_addr = base | 64'h123;
    b_if.req_ready = 1'b1;
    b_if.start     = 1'b1;
    @(negedge clk);
    b_if.start = 1'b0;
    hs_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (b_if.req_valid && b_if.req_ready) begin
        hs_cnt++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          n_checks++;
          if (b_if.req_addr !== e.addr || b_if.req_tag !== e.tag)
            $display("FAIL hold_req got %h/%0d exp %h/%0d", b_if.req_addr, b_if.req_tag, e.addr, e.tag);
          else n_pass++;
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if (hs_cnt != 4 || b_if.req_valid !== 1'b0)
      $display("FAIL hold_count got %0d valid=%b exp 4 valid=0", hs_cnt, b_if.req_valid);
    else n_pass++;
    b_if.cpl_valid = 1'b1;
    b_if.cpl_tag   = 2'd2;
    #1;
    n_checks++;
    if (b_if.cpl_chunk !== 3'd2) $display("FAIL hold_cpl_chunk got %0d exp 2", b_if.cpl_chunk);
    else n_pass++;
    @(negedge clk);
    b_if.cpl_valid = 1'b0;
    n_checks++;
    if (b_if.req_valid !== 1'b1 || b_if.req_tag !== 2'd2 || b_if.req_addr !== base + 64'h800)
      $display("FAIL reuse_tag got %b/%0d/%h exp 1/2/%h", b_if.req_valid, b_if.req_tag, b_if.req_addr, base + 64'h800);
    else n_pass++;
  endtask

  task automatic test_same_cycle();
    logic [63:0] base = 64'hABCD_E000;
    @(negedge clk);
    b_if.cpl_valid = 1'b1;
    b_if.cpl_tag   = 2'd3;
    b_if.req_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (b_if.req_valid !== 1'b1 || b_if.req_tag !== 2'd3 || b_if.req_addr !== base + 64'hA00)
      $display("FAIL same_issue got %b/%0d/%h exp 1/3/%h", b_if.req_valid, b_if.req_tag, b_if.req_addr, base + 64'hA00);
    else n_pass++;
    b_if.cpl_tag   = 2'd1;
    b_if.req_ready = 1'b1;
    #1;
    n_checks++;
    if (b_if.cpl_chunk !== 3'd1) $display("FAIL same_cpl_chunk got %0d exp 1", b_if.cpl_chunk);
    else n_pass++;
    @(negedge clk);
    b_if.cpl_valid = 1'b0;
    n_checks++;
    if (b_if.req_valid !== 1'b1 || b_if.req_tag !== 2'd1 || b_if.req_addr !== base + 64'hC00)
      $display("FAIL same_next got %b/%0d/%h exp 1/1/%h", b_if.req_valid, b_if.req_tag, b_if.req_addr, base + 64'hC00);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (b_if.req_valid !== 1'b0) $display("FAIL same_full got %b exp 0", b_if.req_valid);
    else n_pass++;
    b_if.abort = 1'b1;
    @(negedge clk);
    b_if.abort = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (b_if.busy !== 1'b0 || b_if.done !== 1'b0 || b_if.error !== 1'b0)
        $display("FAIL b_abort got busy=%b done=%b err=%b exp 000", b_if.busy, b_if.done, b_if.error);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    int hs_k, err_k, err_cnt, done_cnt;
    @(negedge clk);
    a_if.page_addr = 64'h3000;
    a_if.req_ready = 1'b1;
    a_if.start     = 1'b1;
    @(negedge clk);
    a_if.start = 1'b0;
    hs_k = -1; err_k = -1; err_cnt = 0; done_cnt = 0;
    for (int k = 0; k < 130; k++) begin
      if (a_if.req_valid && a_if.req_ready) hs_k = k;
      if (a_if.error) begin err_cnt++; err_k = k; end
      if (a_if.done) done_cnt++;
      @(negedge clk);
    end
    n_checks++;
    if (err_cnt != 1 || err_k < hs_k + 101 || err_k > hs_k + 103)
      $display("FAIL timeout got %0d pulses at %0d exp 1 near %0d", err_cnt, err_k, hs_k + 102);
    else n_pass++;
    n_checks++;
    if (done_cnt != 0 || a_if.busy !== 1'b0)
      $display("FAIL timeout_state got done=%0d busy=%b exp 0 0", done_cnt, a_if.busy);
    else n_pass++;
    a_if.cpl_valid = 1'b1;
    a_if.cpl_tag   = 2'd0;
    @(negedge clk);
    a_if.cpl_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (a_if.stat_cpt_stray !== 8'(STATS) || a_if.stat_cpt_req !== 16'(STATS * 8))
      $display("FAIL stray got %0d/%0d exp %0d/%0d", a_if.stat_cpt_stray, a_if.stat_cpt_req, STATS, STATS * 8);
    else n_pass++;
  endtask

  task automatic test_abort();
    int hs_cnt, pulses;
    logic [63:0] base = 64'h2000_0000;
    @(negedge clk);
    a_if.page_addr = base;
    a_if.req_ready = 1'b1;
    a_if.start     = 1'b1;
    @(negedge clk);
    a_if.start = 1'b0;
    @(negedge clk);
    a_if.req_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (a_if.req_valid !== 1'b1 || a_if.req_tag !== 2'd1 || a_if.req_addr !== base + 64'h400)
      $display("FAIL stall_hold got %b/%0d/%h exp 1/1/%h", a_if.req_valid, a_if.req_tag, a_if.req_addr, base + 64'h400);
    else n_pass++;
    a_if.req_ready = 1'b1;
    @(negedge clk);
    a_if.req_ready = 1'b0;
    a_if.abort     = 1'b1;
    @(negedge clk);
    a_if.abort = 1'b0;
    n_checks++;
    if (a_if.busy !== 1'b0 || a_if.req_valid !== 1'b0)
      $display("FAIL abort_idle got busy=%b valid=%b exp 0 0", a_if.busy, a_if.req_valid);
    else n_pass++;
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      if (a_if.done || a_if.error) pulses++;
      @(negedge clk);
    end
    n_checks++;
    if (pulses != 0) $display("FAIL abort_pulse got %0d exp 0", pulses);
    else n_pass++;
    hs_cnt = STATS * 10;
    n_checks++;
    if (a_if.stat_cpt_req !== 16'(hs_cnt)) $display("FAIL abort_stat got %0d exp %0d", a_if.stat_cpt_req, hs_cnt);
    else n_pass++;
    a_if.start = 1'b1;
    @(negedge clk);
    a_if.start = 1'b0;
    n_checks++;
    if (a_if.req_valid !== 1'b1 || a_if.req_tag !== 2'd0 || a_if.req_addr !== base)
      $display("FAIL restart got %b/%0d/%h exp 1/0/%h", a_if.req_valid, a_if.req_tag, a_if.req_addr, base);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    a_if.req_ready = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({a_if.busy, a_if.done, a_if.error, a_if.req_valid} !== 4'b0 || a_if.req_addr !== 64'h0 ||
        a_if.req_tag !== 2'd0 || a_if.stat_cpt_req !== 16'd0 || a_if.stat_cpt_stray !== 8'd0)
      $display("FAIL reset_mid got %b%b%b%b %h %0d exp all zero", a_if.busy, a_if.done, a_if.error,
               a_if.req_valid, a_if.req_addr, a_if.req_tag);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    a_if.start = 1'b0; a_if.abort = 1'b0; a_if.page_addr = '0;
    a_if.req_ready = 1'b0; a_if.cpl_valid = 1'b0; a_if.cpl_tag = '0;
    b_if.start = 1'b0; b_if.abort = 1'b0; b_if.page_addr = '0;
    b_if.req_ready = 1'b0; b_if.cpl_valid = 1'b0; b_if.cpl_tag = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_page_read("page_read");
    test_hold_back();
    test_same_cycle();
    test_timeout();
    test_abort();
    test_reset_mid();
    test_page_read("after_reset");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
